// File: rtl/mem_acc_ctrl.sv
// MEM-stage data-bus controller: puts the EX/MEM load/store onto a single-port
// req/ack bus, shares the bus with a debug requester and stalls the pipe meanwhile.
module mem_acc_ctrl #(
    parameter int XLEN       = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memWrtm,
    input  logic [1:0]      rsltSrcm,
    input  logic [XLEN-1:0] aluRsltm,
    input  logic [XLEN-1:0] wrtDm,
    output logic            stallM,
    output logic [XLEN-1:0] ldDataW,
    output logic            ldVldW,
    output logic            memErr,
    input  logic            dbgReq,
    input  logic            dbgWe,
    input  logic [XLEN-1:0] dbgAddr,
    input  logic [XLEN-1:0] dbgWData,
    output logic            dbgAck,
    output logic [XLEN-1:0] dbgRData,
    output logic            busReq,
    output logic            busWe,
    output logic [XLEN-1:0] busAddr,
    output logic [XLEN-1:0] busWData,
    input  logic [XLEN-1:0] busRData,
    input  logic            busAck
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PIPE_WAIT = 2'd1;
    localparam logic [1:0] DBG_WAIT  = 2'd2;

    localparam int TO_W = $clog2(TIMEOUT);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);

    logic [1:0]      state;
    logic [TO_W-1:0] toCnt;
    logic [SC_W-1:0] starveCnt;
    logic            pipeLoad;

    logic pipeAcc;
    logic dbgPend;
    logic starve;
    logic grantDbg;
    logic grantPipe;
    logic inWait;
    logic toExpire;
    logic waitExit;

    assign pipeAcc   = memWrtm | (rsltSrcm == 2'b01);
    // dbgReq is still high in the cycle dbgAck is shown; masking it prevents a repeat grant.
    assign dbgPend   = dbgReq & ~dbgAck;
    assign starve    = (starveCnt == SC_MAX);
    assign grantDbg  = (state == IDLE) & dbgPend & (~pipeAcc | starve);
    assign grantPipe = (state == IDLE) & ~grantDbg & pipeAcc;
    assign inWait    = (state == PIPE_WAIT) | (state == DBG_WAIT);
    assign toExpire  = (toCnt == TO_LAST);
    assign waitExit  = inWait & (busAck | toExpire);
    assign stallM    = pipeAcc & ~((state == PIPE_WAIT) & (busAck | toExpire));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busReq    <= 1'b0;
            busWe     <= 1'b0;
            busAddr   <= '0;
            busWData  <= '0;
            ldDataW   <= '0;
            ldVldW    <= 1'b0;
            memErr    <= 1'b0;
            dbgAck    <= 1'b0;
            dbgRData  <= '0;
            toCnt     <= '0;
            starveCnt <= '0;
            pipeLoad  <= 1'b0;
        end else begin
            // NOTE: pulses default low here; a later non-blocking assignment in this block overrides it.
            ldVldW <= 1'b0;
            memErr <= 1'b0;
            dbgAck <= 1'b0;

            if (grantDbg) begin
                state    <= DBG_WAIT;
                busReq   <= 1'b1;
                busWe    <= dbgWe;
                busAddr  <= dbgAddr;
                busWData <= dbgWData;
                toCnt    <= '0;
            end else if (grantPipe) begin
                state    <= PIPE_WAIT;
                busReq   <= 1'b1;
                busWe    <= memWrtm;
                busAddr  <= aluRsltm;
                busWData <= wrtDm;
                toCnt    <= '0;
                pipeLoad <= ~memWrtm;
            end else if (waitExit) begin
                state  <= IDLE;
                busReq <= 1'b0;
                if (state == PIPE_WAIT) begin
                    memErr <= ~busAck;
                    if (pipeLoad) begin
                        ldVldW  <= 1'b1;
                        ldDataW <= busAck ? busRData : '0;
                    end
                end else begin
                    dbgAck   <= 1'b1;
                    dbgRData <= busAck ? busRData : '0;
                end
            end else if (inWait) begin
                toCnt <= toCnt + TO_W'(1);
            end

            if (!dbgPend || grantDbg) begin
                starveCnt <= '0;
            end else if (grantPipe && !starve) begin
                starveCnt <= starveCnt + SC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_acc_ctrl.sv
// Self-checking bench for mem_acc_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level bus-ownership model.
module tb_mem_acc_ctrl;

    localparam int XLEN       = 32;
    localparam int TIMEOUT    = 16;
    localparam int STARVE_MAX = 4;

    localparam int OWN_NONE = 0;
    localparam int OWN_PIPE = 1;
    localparam int OWN_DBG  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            memWrtm;
    logic [1:0]      rsltSrcm;
    logic [XLEN-1:0] aluRsltm;
    logic [XLEN-1:0] wrtDm;
    logic            stallM;
    logic [XLEN-1:0] ldDataW;
    logic            ldVldW;
    logic            memErr;
    logic            dbgReq;
    logic            dbgWe;
    logic [XLEN-1:0] dbgAddr;
    logic [XLEN-1:0] dbgWData;
    logic            dbgAck;
    logic [XLEN-1:0] dbgRData;
    logic            busReq;
    logic            busWe;
    logic [XLEN-1:0] busAddr;
    logic [XLEN-1:0] busWData;
    logic [XLEN-1:0] busRData;
    logic            busAck;

    mem_acc_ctrl #(
        .XLEN      (XLEN),
        .TIMEOUT   (TIMEOUT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memWrtm (memWrtm),
        .rsltSrcm(rsltSrcm),
        .aluRsltm(aluRsltm),
        .wrtDm   (wrtDm),
        .stallM  (stallM),
        .ldDataW (ldDataW),
        .ldVldW  (ldVldW),
        .memErr  (memErr),
        .dbgReq  (dbgReq),
        .dbgWe   (dbgWe),
        .dbgAddr (dbgAddr),
        .dbgWData(dbgWData),
        .dbgAck  (dbgAck),
        .dbgRData(dbgRData),
        .busReq  (busReq),
        .busWe   (busWe),
        .busAddr (busAddr),
        .busWData(busWData),
        .busRData(busRData),
        .busAck  (busAck)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, how long it has waited, and the expected registered outputs.
    int              m_owner;
    int              m_waited;
    int              m_starve;
    bit              m_load;
    bit              e_req, e_we, e_ldv, e_err, e_ack;
    logic [XLEN-1:0] e_addr, e_wdata, e_lddata, e_dbgrdata;
    bit              last_stall;

    int obs_stall, obs_ldv, obs_err, obs_req, obs_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = OWN_NONE;
        m_waited   = 0;
        m_starve   = 0;
        m_load     = 1'b0;
        e_req      = 1'b0;
        e_we       = 1'b0;
        e_ldv      = 1'b0;
        e_err      = 1'b0;
        e_ack      = 1'b0;
        e_addr     = '0;
        e_wdata    = '0;
        e_lddata   = '0;
        e_dbgrdata = '0;
        last_stall = 1'b0;
    endtask

    task automatic clear_obs();
        obs_stall = 0;
        obs_ldv   = 0;
        obs_err   = 0;
        obs_req   = 0;
        obs_ack   = 0;
    endtask

    task automatic idle_inputs();
        memWrtm  = 1'b0;
        rsltSrcm = 2'b00;
        aluRsltm = '0;
        wrtDm    = '0;
        dbgReq   = 1'b0;
        dbgWe    = 1'b0;
        dbgAddr  = '0;
        dbgWData = '0;
        busRData = '0;
        busAck   = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge(input bit pipe);
        bit dbg_want;
        dbg_want = dbgReq && !e_ack;
        e_ldv = 1'b0;
        e_err = 1'b0;
        e_ack = 1'b0;
        if (m_owner == OWN_NONE) begin
            if (dbg_want && (!pipe || m_starve == STARVE_MAX)) begin
                m_owner  = OWN_DBG;
                m_waited = 0;
                m_starve = 0;
                e_req    = 1'b1;
                e_we     = dbgWe;
                e_addr   = dbgAddr;
                e_wdata  = dbgWData;
            end else if (pipe) begin
                m_owner  = OWN_PIPE;
                m_waited = 0;
                m_load   = !memWrtm;
                e_req    = 1'b1;
                e_we     = memWrtm;
                e_addr   = aluRsltm;
                e_wdata  = wrtDm;
                if (dbg_want && m_starve < STARVE_MAX) m_starve++;
            end
        end else if (busAck || m_waited == TIMEOUT - 1) begin
            if (m_owner == OWN_PIPE) begin
                e_err = !busAck;
                if (m_load) begin
                    e_ldv    = 1'b1;
                    e_lddata = busAck ? busRData : '0;
                end
            end else begin
                e_ack      = 1'b1;
                e_dbgrdata = busAck ? busRData : '0;
            end
            m_owner = OWN_NONE;
            e_req   = 1'b0;
        end else begin
            m_waited++;
        end
        if (!dbg_want) m_starve = 0;
    endtask

    // One clock: check all outputs mid-cycle, update the model, land 1 unit after the next edge.
    task automatic cycle();
        bit pipe;
        bit e_stall;
        #4;
        pipe    = memWrtm || (rsltSrcm == 2'b01);
        e_stall = pipe && !(m_owner == OWN_PIPE && (busAck || m_waited == TIMEOUT - 1));
        check("stallM", 32'(stallM), 32'(e_stall));
        check("busReq", 32'(busReq), 32'(e_req));
        if (e_req) begin
            check("busWe", 32'(busWe), 32'(e_we));
            check("busAddr", busAddr, e_addr);
            check("busWData", busWData, e_wdata);
        end
        check("ldVldW", 32'(ldVldW), 32'(e_ldv));
        check("ldDataW", ldDataW, e_lddata);
        check("memErr", 32'(memErr), 32'(e_err));
        check("dbgAck", 32'(dbgAck), 32'(e_ack));
        check("dbgRData", dbgRData, e_dbgrdata);
        if (stallM) obs_stall++;
        if (ldVldW) obs_ldv++;
        if (memErr) obs_err++;
        if (busReq) obs_req++;
        if (dbgAck) obs_ack++;
        last_stall = e_stall;
        model_edge(pipe);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pipe_waits;
        bit got_dbg;
        int r;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busReq", 32'(busReq), 32'd0);
        check("rst_busAddr", busAddr, 32'd0);
        check("rst_busWData", busWData, 32'd0);
        check("rst_ldVldW", 32'(ldVldW), 32'd0);
        check("rst_ldDataW", ldDataW, 32'd0);
        check("rst_memErr", 32'(memErr), 32'd0);
        check("rst_dbgAck", 32'(dbgAck), 32'd0);
        check("rst_dbgRData", dbgRData, 32'd0);
        check("rst_stallM", 32'(stallM), 32'd0);
        rst = 1'b0;
        cycle();

        // Load, ack on the third bus cycle.
        clear_obs();
        rsltSrcm = 2'b01;
        aluRsltm = 32'h100;
        repeat (3) cycle();
        busAck   = 1'b1;
        busRData = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        cycle();
        check("t1_stall_cycles", obs_stall, 32'd3);
        check("t1_ldv_pulses", obs_ldv, 32'd1);
        check("t1_ldDataW", ldDataW, 32'hDEAD_BEEF);

        // Store, same-cycle ack.
        clear_obs();
        memWrtm = 1'b1;
        aluRsltm = 32'h200;
        wrtDm    = 32'h1234_5678;
        cycle();
        check("t2_busWe", 32'(busWe), 32'd1);
        check("t2_busAddr", busAddr, 32'h200);
        check("t2_busWData", busWData, 32'h1234_5678);
        busAck = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("t2_stall_cycles", obs_stall, 32'd1);
        check("t2_ldv_pulses", obs_ldv, 32'd0);

        // Load that is never acked: abort after TIMEOUT bus cycles.
        clear_obs();
        rsltSrcm = 2'b01;
        aluRsltm = 32'h300;
        cycle();
        repeat (TIMEOUT) cycle();
        idle_inputs();
        cycle();
        check("t3_busReq_cycles", obs_req, 32'(TIMEOUT));
        check("t3_memErr_pulses", obs_err, 32'd1);
        check("t3_ldv_pulses", obs_ldv, 32'd1);
        check("t3_ldDataW_zero", ldDataW, 32'd0);
        check("t3_stall_cycles", obs_stall, 32'(TIMEOUT));

        // Ack arriving on the timeout cycle wins.
        clear_obs();
        rsltSrcm = 2'b01;
        aluRsltm = 32'h304;
        cycle();
        repeat (TIMEOUT - 1) cycle();
        busAck   = 1'b1;
        busRData = 32'hCAFE_F00D;
        cycle();
        idle_inputs();
        cycle();
        check("t3v_memErr_pulses", obs_err, 32'd0);
        check("t3v_ldv_pulses", obs_ldv, 32'd1);
        check("t3v_ldDataW", ldDataW, 32'hCAFE_F00D);

        // Debug request against back-to-back loads: starvation limit forces a debug grant.
        clear_obs();
        dbgReq   = 1'b1;
        dbgAddr  = 32'h400;
        busRData = 32'h0BAD_F00D;
        rsltSrcm = 2'b01;
        aluRsltm = 32'h1000;
        pipe_waits = 0;
        got_dbg    = 1'b0;
        for (int i = 0; i < 40 && obs_ack == 0; i++) begin
            busAck = busReq;
            if (busReq && busAddr == 32'h400) got_dbg = 1'b1;
            else if (busReq && !got_dbg) pipe_waits++;
            cycle();
            if (!last_stall) aluRsltm = aluRsltm + 32'd4;
        end
        dbgReq = 1'b0;
        busAck = busReq;
        cycle();
        idle_inputs();
        cycle();
        check("t4_pipe_grants_first", pipe_waits, 32'(STARVE_MAX));
        check("t4_dbg_granted", 32'(got_dbg), 32'd1);
        check("t4_dbgAck_pulses", obs_ack, 32'd1);
        check("t4_dbgRData", dbgRData, 32'h0BAD_F00D);

        // Simultaneous requests with no starvation: pipeline first, then debug.
        dbgReq   = 1'b1;
        dbgWe    = 1'b1;
        dbgAddr  = 32'h500;
        dbgWData = 32'h77;
        rsltSrcm = 2'b01;
        aluRsltm = 32'h600;
        cycle();
        check("t5_pipe_first", busAddr, 32'h600);
        busAck = 1'b1;
        cycle();
        memWrtm  = 1'b0;
        rsltSrcm = 2'b00;
        busAck   = 1'b0;
        cycle();
        check("t5_dbg_next_req", 32'(busReq), 32'd1);
        check("t5_dbg_next_addr", busAddr, 32'h500);
        busAck   = 1'b1;
        busRData = 32'h55;
        cycle();
        busAck = 1'b0;
        cycle();
        idle_inputs();
        cycle();

        // Reset in the middle of a pipeline access; stale ack afterwards is ignored.
        rsltSrcm = 2'b01;
        aluRsltm = 32'h700;
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        check("t6_busReq", 32'(busReq), 32'd0);
        check("t6_busAddr", busAddr, 32'd0);
        check("t6_ldDataW", ldDataW, 32'd0);
        check("t6_ldVldW", 32'(ldVldW), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        busAck = 1'b1;
        #1;
        check("t6_stall_from_idle", 32'(stallM), 32'd1);
        cycle();
        busAck = 1'b0;
        cycle();
        busAck   = 1'b1;
        busRData = 32'h66;
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic: phase 0 acks often, phase 1 rarely so timeouts occur.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 1500; i++) begin
                if (!last_stall) begin
                    r = $urandom_range(0, 3);
                    memWrtm = (r == 2);
                    if (r == 1) rsltSrcm = 2'b01;
                    else begin
                        rsltSrcm = 2'($urandom);
                        if (r != 2 && rsltSrcm == 2'b01) rsltSrcm = 2'b10;
                    end
                    aluRsltm = $urandom;
                    wrtDm    = $urandom;
                end
                if (e_ack) dbgReq = 1'b0;
                else if (!dbgReq && $urandom_range(0, 5) == 0) begin
                    dbgReq   = 1'b1;
                    dbgWe    = 1'($urandom);
                    dbgAddr  = $urandom;
                    dbgWData = $urandom;
                end
                busRData = $urandom;
                if (busReq) busAck = (phase == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
                else busAck = ($urandom_range(0, 7) == 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
